f1_start_ctrl: RTL and testbench

F1_START_CTRL -- requirements
Module: f1_start_ctrl

---
 rtl/f1_pkg.sv | 24 ++
 rtl/lfsr7.sv | 20 ++
 rtl/f1_start_ctrl.sv | 154 +++++++++++++++
 tb/tb_f1_start_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// F1 start-light controller shared types and constants.
// State encoding, light pattern, LFSR seed/taps and LFSR step function.
package f1_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_HOLD  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [7:0]  LIGHTS_FULL = 8'hFF;
    localparam logic [6:0]  LFSR_SEED   = 7'h01;
    // x^7 + x^6 + 1: feedback from bits 6 and 5
    localparam logic [6:0]  LFSR_TAPS   = 7'h60;
    localparam logic [15:0] RT_MAX      = 16'hFFFF;

    function automatic logic [6:0] lfsr_next(input logic [6:0] q);
        return {q[5:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr7.sv
// Free-running 7-bit Fibonacci LFSR.
// Maximal-length polynomial, so it never reaches the all-zero state.
module lfsr7
    import f1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] q
);

    // Advance one step every cycle; seed on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer with reaction timer.
// Lights fill on a prescaled tick, hold a random time, then go out.
module f1_start_ctrl
    import f1_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             react,
    input  logic [WIDTH-1:0] N,
    output logic [7:0]       data_out,
    output logic [15:0]      react_time,
    output logic             time_valid,
    output logic             false_start,
    output logic             busy
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] tick_cnt;
    logic [4:0]       hold_cnt;
    logic [15:0]      rt_cnt;
    logic [6:0]       lfsr_q;
    logic             tick;
    logic             armed;
    logic             enter_fill;
    logic             early;
    logic             unused_lfsr_hi;

    lfsr7 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Only the low nibble seeds the hold time
    assign unused_lfsr_hi = ^lfsr_q[6:4];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: react outranks tick in FILL and HOLD
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (trigger) state_nx = S_FILL;
            end
            S_FILL: begin
                if (react) begin
                    state_nx = S_FAULT;
                end else if (tick && data_out == LIGHTS_FULL) begin
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (react) begin
                    state_nx = S_FAULT;
                end else if (tick && hold_cnt == 5'd1) begin
                    state_nx = S_OUT;
                end
            end
            S_OUT: begin
                if (react || rt_cnt == RT_MAX) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Decoded strobes and status outputs
    always_comb begin
        armed      = (state == S_IDLE) || (state == S_DONE) ||
                     (state == S_FAULT);
        enter_fill = armed && trigger;
        early      = ((state == S_FILL) || (state == S_HOLD)) && react;
        busy       = (state == S_FILL) || (state == S_HOLD) ||
                     (state == S_OUT);
        tick       = ((state == S_FILL) || (state == S_HOLD)) &&
                     (tick_cnt == '0);
    end

    // Tick prescaler: period N+1, reloaded on FILL entry and each tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (enter_fill) begin
            tick_cnt <= N;
        end else if ((state == S_FILL) || (state == S_HOLD)) begin
            tick_cnt <= tick ? N : tick_cnt - WIDTH'(1);
        end
    end

    // Light pattern: shift in ones while filling, blank on exit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
        end else if (enter_fill || early ||
                     (state == S_HOLD && state_nx == S_OUT)) begin
            data_out <= '0;
        end else if (state == S_FILL && tick &&
                     data_out != LIGHTS_FULL) begin
            data_out <= {data_out[6:0], 1'b1};
        end
    end

    // Random hold length 1..16 ticks, counted down on each tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (state == S_FILL && state_nx == S_HOLD) begin
            hold_cnt <= {1'b0, lfsr_q[3:0]} + 5'd1;
        end else if (state == S_HOLD && tick) begin
            hold_cnt <= hold_cnt - 5'd1;
        end
    end

    // Reaction counter: zero at lights out, saturates at the timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rt_cnt <= '0;
        end else if (state == S_HOLD && state_nx == S_OUT) begin
            rt_cnt <= '0;
        end else if (state == S_OUT && rt_cnt != RT_MAX) begin
            rt_cnt <= rt_cnt + 16'd1;
        end
    end

    // Result flags: cleared on a new start, held until then
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            react_time  <= '0;
            time_valid  <= 1'b0;
            false_start <= 1'b0;
        end else if (enter_fill) begin
            time_valid  <= 1'b0;
            false_start <= 1'b0;
        end else if (early) begin
            time_valid  <= 1'b0;
            false_start <= 1'b1;
        end else if (state == S_OUT && state_nx == S_DONE) begin
            react_time <= rt_cnt;
            time_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Testbench for f1_start_ctrl.
// Scoreboard of per-cycle light/busy expectations plus scenario checks.
module tb_f1_start_ctrl;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger = 1'b0;
    logic        react = 1'b0;
    logic [15:0] N = 16'd0;
    logic [7:0]  data_out;
    logic [15:0] react_time;
    logic        time_valid;
    logic        false_start;
    logic        busy;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [6:0]  lf_m = 7'h01;
    exp_t        sb[$];

    f1_start_ctrl #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .react       (react),
        .N           (N),
        .data_out    (data_out),
        .react_time  (react_time),
        .time_valid  (time_valid),
        .false_start (false_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] lf_next(input logic [6:0] q);
        return {q[5:0], q[6] ^ q[5]};
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) lf_m = lf_next(lf_m);
        else lf_m = 7'h01;
        #1;
        cyc++;
    endtask

    // Drive a trigger and push the expected light/busy trace to OUT entry
    task automatic launch(input int n, output int c0, output int cout);
        logic [6:0] m;
        int p;
        int h;
        exp_t e;
        N = n[15:0];
        trigger = 1'b1;
        c0 = cyc;
        p = n + 1;
        m = lf_m;
        for (int k = 0; k < 9 * p; k++) m = lf_next(m);
        h = int'(m[3:0]) + 1;
        cout = c0 + 1 + (9 + h) * p;
        for (int c = c0 + 1; c <= cout; c++) begin
            int k;
            k = (c - c0 - 1) / p;
            e.cyc = c;
            e.b = 1'b1;
            if (c == cout) e.d = 8'h00;
            else if (k >= 8) e.d = 8'hFF;
            else e.d = 8'((1 << k) - 1);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        N = 16'd3;
        repeat (3) step();
        checks++;
        if ({data_out, react_time, time_valid, false_start, busy} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%h/%b/%b/%b want all zero",
                     data_out, react_time, time_valid, false_start, busy);
        end
        checks++;
        if (dut.lfsr_q !== 7'h01) begin
            errors++;
            $display("FAIL reset_lfsr got %h want 01", dut.lfsr_q);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (dut.lfsr_q !== lf_m || busy !== 1'b0) begin
                errors++;
                $display("FAIL lfsr_run cyc=%0d got lfsr=%h busy=%b want %h 0",
                         cyc, dut.lfsr_q, busy, lf_m);
            end
        end
    endtask

    task automatic test_fill();
        int c0;
        int cout;
        exp_t e;
        launch(3, c0, cout);
        while (cyc < cout) begin
            step();
            if (cyc == c0 + 1) trigger = 1'b0;
            if (cyc == c0 + 10) trigger = 1'b1;
            if (cyc == c0 + 11) trigger = 1'b0;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || busy !== e.b) begin
                    errors++;
                    $display("FAIL fill_seq cyc=%0d got %h/%b want %h/%b",
                             cyc, data_out, busy, e.d, e.b);
                end
            end
        end
        react = 1'b1;
        step();
        react = 1'b0;
        checks++;
        if (react_time !== 16'd0 || time_valid !== 1'b1 || busy !== 1'b0 ||
            false_start !== 1'b0) begin
            errors++;
            $display("FAIL first_out_react got rt=%0d tv=%b busy=%b fs=%b want 0 1 0 0",
                     react_time, time_valid, busy, false_start);
        end
    endtask

    task automatic test_reaction();
        int c0;
        int cout;
        exp_t e;
        launch(0, c0, cout);
        while (cyc < cout) begin
            step();
            if (cyc == c0 + 1) trigger = 1'b0;
            if (cyc == c0 + 1) begin
                checks++;
                if (time_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_clears_valid got %b want 0", time_valid);
                end
            end
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || busy !== e.b) begin
                    errors++;
                    $display("FAIL react_seq cyc=%0d got %h/%b want %h/%b",
                             cyc, data_out, busy, e.d, e.b);
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (busy !== 1'b1 || data_out !== 8'h00 || time_valid !== 1'b0) begin
                errors++;
                $display("FAIL out_wait cyc=%0d got busy=%b d=%h tv=%b want 1 00 0",
                         cyc, busy, data_out, time_valid);
            end
        end
        react = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (react_time !== 16'd10 || time_valid !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL react_10 cyc=%0d got rt=%0d tv=%b busy=%b want 10 1 0",
                         cyc, react_time, time_valid, busy);
            end
        end
        react = 1'b0;
    endtask

    task automatic test_false_start();
        int c0;
        int cout;
        exp_t e;
        launch(0, c0, cout);
        while (cyc < c0 + 5) begin
            step();
            if (cyc == c0 + 1) trigger = 1'b0;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || busy !== e.b) begin
                    errors++;
                    $display("FAIL fs_seq cyc=%0d got %h/%b want %h/%b",
                             cyc, data_out, busy, e.d, e.b);
                end
            end
        end
        sb.delete();
        react = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (false_start !== 1'b1 || data_out !== 8'h00 ||
                time_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL false_start cyc=%0d got fs=%b d=%h tv=%b busy=%b want 1 00 0 0",
                         cyc, false_start, data_out, time_valid, busy);
            end
        end
        react = 1'b0;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        checks++;
        if (false_start !== 1'b0 || busy !== 1'b1 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL fs_clear got fs=%b busy=%b d=%h want 0 1 00",
                     false_start, busy, data_out);
        end
        react = 1'b1;
        step();
        react = 1'b0;
        checks++;
        if (false_start !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fs_again got fs=%b busy=%b want 1 0", false_start, busy);
        end
    endtask

    task automatic test_final_tick();
        int c0;
        int cout;
        exp_t e;
        launch(0, c0, cout);
        while (cyc < cout - 1) begin
            step();
            if (cyc == c0 + 1) trigger = 1'b0;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || busy !== e.b) begin
                    errors++;
                    $display("FAIL ft_seq cyc=%0d got %h/%b want %h/%b",
                             cyc, data_out, busy, e.d, e.b);
                end
            end
        end
        sb.delete();
        react = 1'b1;
        step();
        react = 1'b0;
        checks++;
        if (false_start !== 1'b1 || busy !== 1'b0 || data_out !== 8'h00 ||
            time_valid !== 1'b0) begin
            errors++;
            $display("FAIL final_tick_react got fs=%b busy=%b d=%h tv=%b want 1 0 00 0",
                     false_start, busy, data_out, time_valid);
        end
    endtask

    task automatic test_timeout();
        int c0;
        int cout;
        exp_t e;
        launch(0, c0, cout);
        while (cyc < cout) begin
            step();
            if (cyc == c0 + 1) trigger = 1'b0;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || busy !== e.b) begin
                    errors++;
                    $display("FAIL to_seq cyc=%0d got %h/%b want %h/%b",
                             cyc, data_out, busy, e.d, e.b);
                end
            end
        end
        repeat (65535) step();
        checks++;
        if (busy !== 1'b1 || time_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got busy=%b tv=%b want 1 0", busy, time_valid);
        end
        step();
        checks++;
        if (react_time !== 16'hFFFF || time_valid !== 1'b1 || busy !== 1'b0 ||
            false_start !== 1'b0) begin
            errors++;
            $display("FAIL timeout got rt=%h tv=%b busy=%b fs=%b want FFFF 1 0 0",
                     react_time, time_valid, busy, false_start);
        end
    endtask

    task automatic test_reset_hold();
        int c0;
        int cout;
        exp_t e;
        launch(3, c0, cout);
        while (cyc < c0 + 38) begin
            step();
            if (cyc == c0 + 1) trigger = 1'b0;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || busy !== e.b) begin
                    errors++;
                    $display("FAIL rh_seq cyc=%0d got %h/%b want %h/%b",
                             cyc, data_out, busy, e.d, e.b);
                end
            end
        end
        sb.delete();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({data_out, react_time, time_valid, false_start, busy} !== 27'd0 ||
            dut.lfsr_q !== 7'h01) begin
            errors++;
            $display("FAIL async_reset got d=%h rt=%h tv=%b fs=%b busy=%b lfsr=%h want zeros lfsr 01",
                     data_out, react_time, time_valid, false_start, busy, dut.lfsr_q);
        end
        repeat (2) step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            react = (i % 2 == 0);
            step();
            checks++;
            if (busy !== 1'b0 || data_out !== 8'h00 || false_start !== 1'b0 ||
                dut.lfsr_q !== lf_m) begin
                errors++;
                $display("FAIL post_reset_idle cyc=%0d got busy=%b d=%h fs=%b lfsr=%h want 0 00 0 %h",
                         cyc, busy, data_out, false_start, dut.lfsr_q, lf_m);
            end
        end
        react = 1'b0;
        launch(3, c0, cout);
        while (cyc < c0 + 5) begin
            step();
            if (cyc == c0 + 1) trigger = 1'b0;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || busy !== e.b) begin
                    errors++;
                    $display("FAIL restart_seq cyc=%0d got %h/%b want %h/%b",
                             cyc, data_out, busy, e.d, e.b);
                end
            end
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_reaction();
        test_false_start();
        test_final_tick();
        test_timeout();
        test_reset_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
